instruction_memory: RTL and testbench

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

---
 rtl/instruction_memory.sv | 124 ++++++++++++
 tb/tb_instruction_memory.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// Byte-addressed 1 KiB instruction memory with a fixed multi-cycle fetch handshake.
// Fetches assemble four bytes little-endian; the programming port writes single bytes.
module instruction_memory #(
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        read,
    input  logic [9:0]  address,
    output logic [31:0] instruction,
    output logic        busywait,
    input  logic        prog_en,
    input  logic [9:0]  prog_addr,
    input  logic [7:0]  prog_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The IDLE request cycle counts as the first busy cycle, so BUSY ends at count LATENCY-1.
    localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [9:0]  addr_reg, addr_next;
    logic [1:0]  rot_reg;
    logic        load;
    logic [3:0][7:0] bank_q;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        load       = 1'b0;
        busywait   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (read) begin
                    busywait   = 1'b1;
                    addr_next  = address;
                    count_next = 4'd1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (count_reg == LAST_COUNT) begin
                    load       = 1'b1;
                    count_next = 4'd0;
                    state_next = DONE;
                end else begin
                    count_next = count_reg + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (RESET) begin
            busywait = 1'b0;
            load     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            rot_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (load) begin
                rot_reg <= addr_reg[1:0];
            end
        end
        addr_reg <= addr_next;
    end

    // Four byte-wide banks interleaved on address[1:0]: any four consecutive bytes,
    // aligned or not, touch each bank exactly once, so every bank needs one read port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [7:0] bank_mem [256];
            logic [7:0] q_reg;
            logic [1:0] lane;
            logic [9:0] lane_addr;

            assign lane      = 2'(gi) - addr_reg[1:0];
            assign lane_addr = addr_reg + {8'd0, lane};

            always_ff @(posedge CLK) begin
                if (prog_en && (prog_addr[1:0] == 2'(gi))) begin
                    bank_mem[prog_addr[9:2]] <= prog_data;
                end
            end

            // Registered read samples the pre-write byte when a program write hits the same edge.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    q_reg <= 8'h00;
                end else if (load) begin
                    q_reg <= bank_mem[lane_addr[9:2]];
                end
            end

            assign bank_q[gi] = q_reg;
        end

        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [1:0] sel;
            assign sel = rot_reg + 2'(gi);
            assign instruction[8*gi +: 8] = bank_q[sel];
        end
    endgenerate

endmodule

// File: tb/tb_instruction_memory.sv
// Randomized self-checking bench for instruction_memory against a byte-array
// reference model and a busywait cycle counter.
module tb_instruction_memory;

    localparam int LAT = 4;

    logic        CLK;
    logic        RESET;
    logic        read;
    logic [9:0]  address;
    logic [31:0] instruction;
    logic        busywait;
    logic        prog_en;
    logic [9:0]  prog_addr;
    logic [7:0]  prog_data;

    logic [7:0]  ref_mem [1024];
    int          checks;
    int          failures;

    instruction_memory #(.LATENCY(LAT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .read        (read),
        .address     (address),
        .instruction (instruction),
        .busywait    (busywait),
        .prog_en     (prog_en),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_word(input logic [9:0] a);
        logic [9:0] a1, a2, a3;
        a1 = a + 10'd1;
        a2 = a + 10'd2;
        a3 = a + 10'd3;
        return {ref_mem[a3], ref_mem[a2], ref_mem[a1], ref_mem[a]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic prog_byte(input logic [9:0] a, input logic [7:0] d);
        prog_en   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        ref_mem[a] = d;
        prog_en = 1'b0;
    endtask

    // Drives one fetch, counts busywait-high cycles and records the word the model
    // expects at the edge where busywait drops. Optional random program writes.
    task automatic run_fetch(input logic [9:0] a, input bit drop, input bit rand_prog,
                             output int busy_n, output logic [31:0] exp_w,
                             output bit stable);
        logic [31:0] held;
        logic        pe;
        logic [9:0]  pa;
        logic [7:0]  pd;
        read    = 1'b1;
        address = a;
        #1;
        held   = instruction;
        busy_n = 0;
        stable = 1'b1;
        exp_w  = ref_word(a);
        while (busywait === 1'b1 && busy_n < 40) begin
            busy_n++;
            if (instruction !== held) stable = 1'b0;
            pe = rand_prog && ($urandom_range(0, 2) == 0);
            pa = 10'($urandom);
            pd = 8'($urandom);
            prog_en   = pe;
            prog_addr = pa;
            prog_data = pd;
            exp_w = ref_word(a);
            tick();
            if (pe) ref_mem[pa] = pd;
            prog_en = 1'b0;
            if (drop) begin
                read    = 1'b0;
                address = 10'($urandom);
            end
            #1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; read = 1'b1; address = 10'd0;
        tick(); tick();
        checks++;
        if (busywait !== 1'b0) begin
            failures++;
            $display("FAIL reset_busywait: got %b want 0", busywait);
        end
        checks++;
        if (instruction !== 32'h0) begin
            failures++;
            $display("FAIL reset_instruction: got %h want 00000000", instruction);
        end
        RESET = 1'b0; read = 1'b0;
        tick();
        checks++;
        if (busywait !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_read: got %b want 0", busywait);
        end
        $display("reset: busywait=%b instruction=%h", busywait, instruction);
    endtask

    task automatic test_basic();
        int busy_n; logic [31:0] w; bit st;
        prog_byte(10'd0, 8'h05); prog_byte(10'd1, 8'h00);
        prog_byte(10'd2, 8'h00); prog_byte(10'd3, 8'h00);
        run_fetch(10'd0, 1'b0, 1'b0, busy_n, w, st);
        checks++;
        if (busy_n != LAT) begin
            failures++;
            $display("FAIL basic_latency: got %0d want %0d", busy_n, LAT);
        end
        checks++;
        if (instruction !== 32'h00000005) begin
            failures++;
            $display("FAIL basic_word: got %h want 00000005", instruction);
        end
        read = 1'b0;
        tick();
        checks++;
        if (busywait !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: got %b want 0", busywait);
        end
        $display("fetch addr=0 busy=%0d instruction=%h", busy_n, instruction);
    endtask

    task automatic test_wrap();
        int busy_n; logic [31:0] w; bit st;
        prog_byte(10'd1022, 8'hAA); prog_byte(10'd1023, 8'hBB);
        prog_byte(10'd0, 8'hCC);    prog_byte(10'd1, 8'hDD);
        run_fetch(10'd1022, 1'b0, 1'b0, busy_n, w, st);
        checks++;
        if (instruction !== 32'hDDCCBBAA || busy_n != LAT) begin
            failures++;
            $display("FAIL wrap_word: got %h busy=%0d want ddccbbaa busy=%0d", instruction, busy_n, LAT);
        end
        read = 1'b0;
        tick();
        $display("fetch addr=1022 busy=%0d instruction=%h", busy_n, instruction);
        // Restore the bytes the back-to-back test expects at 0..3.
        prog_byte(10'd0, 8'h05); prog_byte(10'd1, 8'h00);
    endtask

    task automatic test_address_change();
        int busy_n; logic [31:0] w; bit st;
        prog_byte(10'd4, 8'h11); prog_byte(10'd5, 8'h22);
        prog_byte(10'd6, 8'h33); prog_byte(10'd7, 8'h44);
        prog_byte(10'd8, 8'h99); prog_byte(10'd9, 8'h88);
        run_fetch(10'd4, 1'b1, 1'b0, busy_n, w, st);
        checks++;
        if (instruction !== 32'h44332211 || busy_n != LAT || !st) begin
            failures++;
            $display("FAIL addr_change: got %h busy=%0d stable=%0d want 44332211 busy=%0d stable=1",
                     instruction, busy_n, st, LAT);
        end
        read = 1'b0; address = 10'd8;
        tick();
        checks++;
        if (busywait !== 1'b0) begin
            failures++;
            $display("FAIL addr_change_idle: got %b want 0", busywait);
        end
        $display("fetch addr=4 with mid-busy change busy=%0d instruction=%h", busy_n, instruction);
    endtask

    task automatic test_back_to_back();
        int busy_n; logic [31:0] w; bit st;
        run_fetch(10'd0, 1'b0, 1'b0, busy_n, w, st);
        checks++;
        if (instruction !== 32'h00000005 || busy_n != LAT || busywait !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got %h busy=%0d bw=%b want 00000005 busy=%0d bw=0",
                     instruction, busy_n, busywait, LAT);
        end
        address = 10'd4;
        tick();
        run_fetch(10'd4, 1'b0, 1'b0, busy_n, w, st);
        checks++;
        if (instruction !== 32'h44332211 || busy_n != LAT) begin
            failures++;
            $display("FAIL b2b_second: got %h busy=%0d want 44332211 busy=%0d", instruction, busy_n, LAT);
        end
        read = 1'b0;
        tick();
        $display("back-to-back fetch 0,4 second busy=%0d instruction=%h", busy_n, instruction);
    endtask

    task automatic test_reset_mid_busy();
        int busy_n; logic [31:0] w; bit st;
        read = 1'b1; address = 10'd8;
        tick();
        RESET = 1'b1;
        prog_en = 1'b1; prog_addr = 10'd100; prog_data = 8'h5A;
        #1;
        checks++;
        if (busywait !== 1'b0) begin
            failures++;
            $display("FAIL midreset_busywait: got %b want 0", busywait);
        end
        tick();
        ref_mem[100] = 8'h5A;
        RESET = 1'b0; prog_en = 1'b0; read = 1'b0;
        #1;
        checks++;
        if (instruction !== 32'h0 || busywait !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: got %h bw=%b want 00000000 bw=0", instruction, busywait);
        end
        run_fetch(10'd100, 1'b0, 1'b0, busy_n, w, st);
        checks++;
        if (instruction !== ref_word(10'd100) || instruction[7:0] !== 8'h5A || busy_n != LAT) begin
            failures++;
            $display("FAIL midreset_refetch: got %h busy=%0d want %h busy=%0d",
                     instruction, busy_n, ref_word(10'd100), LAT);
        end
        read = 1'b0;
        tick();
        $display("reset mid-busy then fetch addr=100 instruction=%h", instruction);
    endtask

    task automatic test_collision();
        int busy_n; logic [31:0] w, old_w; bit st;
        prog_byte(10'd201, 8'h12);
        old_w = ref_word(10'd200);
        read = 1'b1; address = 10'd200;
        for (int i = 1; i <= LAT; i++) begin
            if (i == LAT) begin
                prog_en = 1'b1; prog_addr = 10'd201; prog_data = 8'h7F;
            end
            tick();
            prog_en = 1'b0;
        end
        ref_mem[201] = 8'h7F;
        checks++;
        if (instruction !== old_w || busywait !== 1'b0) begin
            failures++;
            $display("FAIL collision_old: got %h bw=%b want %h bw=0", instruction, busywait, old_w);
        end
        read = 1'b0;
        tick();
        run_fetch(10'd200, 1'b0, 1'b0, busy_n, w, st);
        checks++;
        if (instruction[15:8] !== 8'h7F || instruction !== ref_word(10'd200)) begin
            failures++;
            $display("FAIL collision_new: got %h want %h", instruction, ref_word(10'd200));
        end
        read = 1'b0;
        tick();
        $display("collision fetch addr=200 old=%h new=%h", old_w, instruction);
    endtask

    task automatic test_random();
        int busy_n; logic [31:0] w; bit st; bit drop; logic [9:0] a;
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                read = 1'b0;
                tick();
                checks++;
                if (busywait !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_idle: got %b want 0", busywait);
                end
            end
            a    = 10'($urandom);
            drop = 1'($urandom);
            run_fetch(a, drop, 1'b1, busy_n, w, st);
            checks++;
            if (instruction !== w || busy_n != LAT || !st) begin
                failures++;
                $display("FAIL rand_fetch: addr=%0d got %h busy=%0d stable=%0d want %h busy=%0d stable=1",
                         a, instruction, busy_n, st, w, LAT);
            end
            $display("random fetch addr=%0d drop=%0d instruction=%h", a, drop, instruction);
            read = 1'b0;
            tick();
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        RESET = 1'b1; read = 1'b0; address = 10'd0;
        prog_en = 1'b0; prog_addr = 10'd0; prog_data = 8'd0;
        test_reset();
        for (int i = 0; i < 1024; i++) prog_byte(10'(i), 8'($urandom));
        test_basic();
        test_wrap();
        test_address_change();
        test_back_to_back();
        test_reset_mid_busy();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
